// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath width, instruction field positions and the
// opcodes the operand fetch stage needs to recognise.
package cpu_defs;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OPC_W  = 6;
  localparam int IMM_W  = 16;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;

  typedef logic [REG_W-1:0] reg_addr_t;

  // Logical immediates are zero-extended; every other opcode sign-extends.
  function automatic logic imm_is_zext(input logic [OPC_W-1:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Next-value select for one source operand: fresh read or write-back bypass on
// accept, and write-back refresh of the held operand while stalled.
module operand_bypass #(
  parameter int DATA_W = 32
) (
  input  logic              accept_i,
  input  logic              hold_i,
  input  logic [4:0]        new_addr_i,
  input  logic [DATA_W-1:0] new_data_i,
  input  logic [4:0]        held_addr_i,
  input  logic [DATA_W-1:0] held_data_i,
  input  logic              wb_enable_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              bypass_o
);

  // Register 0 reads as zero and can never be the target of a bypass.
  always_comb begin
    data_o   = held_data_i;
    bypass_o = 1'b0;
    if (accept_i) begin
      if (new_addr_i == 5'd0) begin
        data_o = '0;
      end else if (wb_enable_i && (wb_addr_i == new_addr_i)) begin
        data_o   = wb_data_i;
        bypass_o = 1'b1;
      end else begin
        data_o = new_data_i;
      end
    end else if (hold_i && wb_enable_i && (wb_addr_i != 5'd0) &&
                 (wb_addr_i == held_addr_i)) begin
      data_o   = wb_data_i;
      bypass_o = 1'b1;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes the instruction, selects both source operands
// with write-back bypass and presents a registered payload to the ALU.
module operand_fetch #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic [4:0]        readReg1,
  output logic [4:0]        readReg2,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic              wb_enable,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_opA,
  output logic [DATA_W-1:0] out_opB,
  output logic [DATA_W-1:0] out_imm,
  output logic [4:0]        out_rd,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct,
  output logic [CNT_W-1:0]  bypass_count
);
  import cpu_defs::REG_W;
  import cpu_defs::OPC_W;
  import cpu_defs::IMM_W;
  import cpu_defs::OPC_LSB;
  import cpu_defs::RS_LSB;
  import cpu_defs::RT_LSB;
  import cpu_defs::RD_LSB;
  import cpu_defs::FUNCT_LSB;
  import cpu_defs::OP_RTYPE;
  import cpu_defs::reg_addr_t;
  import cpu_defs::imm_is_zext;

  logic              accept;
  logic              hold;
  logic              bypassA;
  logic              bypassB;
  logic [OPC_W-1:0]  opcode;
  reg_addr_t         rs;
  reg_addr_t         rt;
  reg_addr_t         rd_d;
  logic [DATA_W-1:0] opA_d;
  logic [DATA_W-1:0] opB_d;
  logic [DATA_W-1:0] imm_d;

  logic              valid_q;
  logic [DATA_W-1:0] opA_q;
  logic [DATA_W-1:0] opB_q;
  logic [DATA_W-1:0] imm_q;
  reg_addr_t         rd_q;
  reg_addr_t         heldRs_q;
  reg_addr_t         heldRt_q;
  logic [OPC_W-1:0]  opcode_q;
  logic [OPC_W-1:0]  funct_q;
  logic [CNT_W-1:0]  bypassCount_q;

  assign opcode   = instr[OPC_LSB +: OPC_W];
  assign rs       = instr[RS_LSB +: REG_W];
  assign rt       = instr[RT_LSB +: REG_W];
  assign readReg1 = rs;
  assign readReg2 = rt;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign hold     = valid_q && !out_ready;

  assign rd_d  = (opcode == OP_RTYPE) ? instr[RD_LSB +: REG_W] : rt;
  assign imm_d = imm_is_zext(opcode) ?
                 {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]} :
                 {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  operand_bypass #(.DATA_W(DATA_W)) u_bypassA (
    .accept_i    (accept),
    .hold_i      (hold),
    .new_addr_i  (rs),
    .new_data_i  (readData1),
    .held_addr_i (heldRs_q),
    .held_data_i (opA_q),
    .wb_enable_i (wb_enable),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .data_o      (opA_d),
    .bypass_o    (bypassA)
  );

  operand_bypass #(.DATA_W(DATA_W)) u_bypassB (
    .accept_i    (accept),
    .hold_i      (hold),
    .new_addr_i  (rt),
    .new_data_i  (readData2),
    .held_addr_i (heldRt_q),
    .held_data_i (opB_q),
    .wb_enable_i (wb_enable),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .data_o      (opB_d),
    .bypass_o    (bypassB)
  );

  // Operands always take the bypass unit's result; it returns the held value
  // when nothing should change, so only the decoded fields need gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      opA_q         <= '0;
      opB_q         <= '0;
      imm_q         <= '0;
      rd_q          <= '0;
      heldRs_q      <= '0;
      heldRt_q      <= '0;
      opcode_q      <= '0;
      funct_q       <= '0;
      bypassCount_q <= '0;
    end else begin
      opA_q <= opA_d;
      opB_q <= opB_d;
      if (accept) begin
        valid_q  <= 1'b1;
        imm_q    <= imm_d;
        rd_q     <= rd_d;
        heldRs_q <= rs;
        heldRt_q <= rt;
        opcode_q <= opcode;
        funct_q  <= instr[FUNCT_LSB +: OPC_W];
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if ((bypassA || bypassB) && (bypassCount_q != '1)) begin
        bypassCount_q <= bypassCount_q + CNT_W'(1);
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_opA      = opA_q;
  assign out_opB      = opB_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_opcode   = opcode_q;
  assign out_funct    = funct_q;
  assign bypass_count = bypassCount_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a randomized
// stream compared against a behavioural model of the stage and register file.
module tb_operand_fetch;
  localparam int DW = 32;
  localparam int CW = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, wb_enable;
  logic [31:0]   instr;
  logic [4:0]    readReg1, readReg2, wb_addr, out_rd;
  logic [DW-1:0] readData1, readData2, wb_data, out_opA, out_opB, out_imm;
  logic [5:0]    out_opcode, out_funct;
  logic [CW-1:0] bypass_count;

  logic [DW-1:0] rf [32];
  int total = 0;
  int bad   = 0;

  logic          mValid;
  logic [DW-1:0] mOpA, mOpB, mImm;
  logic [4:0]    mRd, mRs, mRt;
  logic [5:0]    mOpc, mFunct;
  int            mCount;

  always #5 clk = ~clk;

  assign readData1 = rf[instr[25:21]];
  assign readData2 = rf[instr[20:16]];

  operand_fetch #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1), .readData2(readData2),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opA(out_opA), .out_opB(out_opB),
    .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode), .out_funct(out_funct),
    .bypass_count(bypass_count)
  );

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Source value as seen at accept: r0 is zero, a same-cycle write wins, else the file.
  function automatic logic [DW-1:0] srcValue(input logic [4:0] r, output logic took);
    took = 1'b0;
    if (r == 5'd0) return '0;
    if (wb_enable && wb_addr == r) begin
      took = 1'b1;
      return wb_data;
    end
    return rf[r];
  endfunction

  task automatic modelReset();
    mValid = 1'b0; mOpA = '0; mOpB = '0; mImm = '0;
    mRd = '0; mRs = '0; mRt = '0; mOpc = '0; mFunct = '0; mCount = 0;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd, input logic rdy);
    in_valid = v; instr = ins; wb_enable = we; wb_addr = wa; wb_data = wd; out_ready = rdy;
  endtask

  // Advances one clock: predicts the stage from the current inputs, then commits
  // the prediction and the register-file write just after the edge.
  task automatic step();
    logic          acc, t1, t2, bump, nValid;
    logic [DW-1:0] nA, nB, nImm;
    logic [4:0]    nRd, nRs, nRt;
    logic [5:0]    nOpc, nFunct;
    acc = in_valid && (!mValid || out_ready);
    bump = 1'b0;
    nValid = mValid; nA = mOpA; nB = mOpB; nImm = mImm;
    nRd = mRd; nRs = mRs; nRt = mRt; nOpc = mOpc; nFunct = mFunct;
    if (acc) begin
      nValid = 1'b1;
      nRs = instr[25:21];
      nRt = instr[20:16];
      nA = srcValue(nRs, t1);
      nB = srcValue(nRt, t2);
      bump = t1 | t2;
      nOpc = instr[31:26];
      nFunct = instr[5:0];
      nRd = (nOpc == 6'h00) ? instr[15:11] : instr[20:16];
      if (nOpc == 6'h0C || nOpc == 6'h0D || nOpc == 6'h0E) nImm = {16'h0000, instr[15:0]};
      else nImm = DW'($signed(instr[15:0]));
    end else if (mValid && out_ready) begin
      nValid = 1'b0;
    end else if (mValid && wb_enable && wb_addr != 5'd0) begin
      if (wb_addr == mRs) begin nA = wb_data; bump = 1'b1; end
      if (wb_addr == mRt) begin nB = wb_data; bump = 1'b1; end
    end
    @(posedge clk);
    #1;
    if (wb_enable && wb_addr != 5'd0) rf[wb_addr] = wb_data;
    mValid = nValid; mOpA = nA; mOpB = nB; mImm = nImm;
    mRd = nRd; mRs = nRs; mRt = nRt; mOpc = nOpc; mFunct = nFunct;
    if (bump && mCount < CNT_MAX) mCount++;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, rType(5'd1, 5'd2, 5'd3, 6'h20), 1'b0, 5'd0, '0, 1'b0);
    #1 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
    total++; if ({out_opA, out_opB, out_imm} !== '0) begin bad++; $display("[TB] FAIL reset_ops got=%h %h %h want=0", out_opA, out_opB, out_imm); end
    total++; if ({out_rd, out_opcode, out_funct} !== '0) begin bad++; $display("[TB] FAIL reset_fields got=%h %h %h want=0", out_rd, out_opcode, out_funct); end
    total++; if (bypass_count !== '0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", bypass_count); end
    @(posedge clk); @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold_valid got=%b want=0", out_valid); end
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, 5'd0, '0, 1'b0);
    rst = 1'b0;
    modelReset();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    rf[2] = 32'h12345678; rf[3] = 32'h00000111;
    applyStimulus(1'b1, rType(5'd2, 5'd3, 5'd4, 6'h20), 1'b0, 5'd0, '0, 1'b1);
    #1;
    total++; if ({readReg1, readReg2} !== {5'd2, 5'd3}) begin bad++; $display("[TB] FAIL basic_readregs got=%0d,%0d want=2,3", readReg1, readReg2); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%b want=1", out_valid); end
    total++; if (out_opA !== 32'h12345678) begin bad++; $display("[TB] FAIL basic_opA got=%h want=12345678", out_opA); end
    total++; if (out_opB !== 32'h00000111) begin bad++; $display("[TB] FAIL basic_opB got=%h want=00000111", out_opB); end
    total++; if (out_rd !== 5'd4) begin bad++; $display("[TB] FAIL basic_rd got=%0d want=4", out_rd); end
    total++; if ({out_opcode, out_funct} !== {6'h00, 6'h20}) begin bad++; $display("[TB] FAIL basic_opc_funct got=%h,%h want=00,20", out_opcode, out_funct); end
    total++; if (out_imm !== 32'h00002020) begin bad++; $display("[TB] FAIL basic_imm got=%h want=00002020", out_imm); end
    total++; if (bypass_count !== 6'd0) begin bad++; $display("[TB] FAIL basic_count got=%0d want=0", bypass_count); end
    applyStimulus(1'b0, '0, 1'b0, 5'd0, '0, 1'b1);
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_bypass_accept();
    rf[3] = 32'h11111111; rf[7] = 32'h00000077;
    applyStimulus(1'b1, iType(6'h08, 5'd3, 5'd7, 16'h0010), 1'b1, 5'd3, 32'hABCDEF01, 1'b1);
    step();
    total++; if (out_opA !== 32'hABCDEF01) begin bad++; $display("[TB] FAIL bypass_opA got=%h want=abcdef01", out_opA); end
    total++; if (out_opB !== 32'h00000077) begin bad++; $display("[TB] FAIL bypass_opB got=%h want=00000077", out_opB); end
    total++; if (out_rd !== 5'd7) begin bad++; $display("[TB] FAIL bypass_rd got=%0d want=7", out_rd); end
    total++; if (bypass_count !== 6'd1) begin bad++; $display("[TB] FAIL bypass_count got=%0d want=1", bypass_count); end
    applyStimulus(1'b0, '0, 1'b0, 5'd0, '0, 1'b1);
    step();
  endtask

  task automatic test_hold_update();
    rf[5] = 32'h55555555; rf[6] = 32'h66666666;
    applyStimulus(1'b1, iType(6'h08, 5'd5, 5'd6, 16'h0004), 1'b0, 5'd0, '0, 1'b0);
    step();
    total++; if (out_opA !== 32'h55555555) begin bad++; $display("[TB] FAIL hold_first_opA got=%h want=55555555", out_opA); end
    applyStimulus(1'b1, rType(5'd9, 5'd10, 5'd11, 6'h22), 1'b1, 5'd5, 32'hFEDCBA98, 1'b0);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_in_ready got=%b want=0", in_ready); end
    step();
    total++; if (out_opA !== 32'hFEDCBA98) begin bad++; $display("[TB] FAIL hold_opA got=%h want=fedcba98", out_opA); end
    total++; if (out_opB !== 32'h66666666) begin bad++; $display("[TB] FAIL hold_opB got=%h want=66666666", out_opB); end
    total++; if ({out_opcode, out_rd} !== {6'h08, 5'd6}) begin bad++; $display("[TB] FAIL hold_stable got=%h,%0d want=08,6", out_opcode, out_rd); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_in_ready2 got=%b want=0", in_ready); end
    total++; if (bypass_count !== 6'd2) begin bad++; $display("[TB] FAIL hold_count got=%0d want=2", bypass_count); end
    applyStimulus(1'b0, '0, 1'b0, 5'd0, '0, 1'b1);
    step();
  endtask

  task automatic test_imm();
    logic [5:0]  opcs [4]    = '{6'h0C, 6'h0E, 6'h23, 6'h00};
    logic [31:0] wantImm [4] = '{32'h00008000, 32'h00008000, 32'hFFFF8000, 32'hFFFF8000};
    logic [4:0]  wantRd [4]  = '{5'd2, 5'd2, 5'd2, 5'd16};
    applyStimulus(1'b1, iType(6'h0D, 5'd1, 5'd2, 16'h8000), 1'b0, 5'd0, '0, 1'b1);
    step();
    total++; if (out_imm !== 32'h00008000) begin bad++; $display("[TB] FAIL imm_ori got=%h want=00008000", out_imm); end
    applyStimulus(1'b1, iType(6'h08, 5'd1, 5'd2, 16'h8000), 1'b0, 5'd0, '0, 1'b1);
    step();
    total++; if ({out_valid, out_imm} !== {1'b1, 32'hFFFF8000}) begin bad++; $display("[TB] FAIL imm_addi got=%b,%h want=1,ffff8000", out_valid, out_imm); end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, iType(opcs[k], 5'd1, 5'd2, 16'h8000), 1'b0, 5'd0, '0, 1'b1);
      step();
      total++; if ({out_imm, out_rd} !== {wantImm[k], wantRd[k]}) begin bad++; $display("[TB] FAIL imm_table[%0d] got=%h,%0d want=%h,%0d", k, out_imm, out_rd, wantImm[k], wantRd[k]); end
    end
    applyStimulus(1'b0, '0, 1'b0, 5'd0, '0, 1'b1);
    step();
  endtask

  task automatic test_zero_reg();
    rf[0] = 32'hDEADBEEF;
    applyStimulus(1'b1, iType(6'h08, 5'd0, 5'd0, 16'h0001), 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    step();
    total++; if ({out_opA, out_opB} !== 64'd0) begin bad++; $display("[TB] FAIL zero_accept got=%h,%h want=0,0", out_opA, out_opB); end
    total++; if (bypass_count !== 6'd2) begin bad++; $display("[TB] FAIL zero_count got=%0d want=2", bypass_count); end
    applyStimulus(1'b0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    step();
    total++; if ({out_valid, out_opA, bypass_count} !== {1'b1, 32'd0, 6'd2}) begin bad++; $display("[TB] FAIL zero_held got=%b,%h,%0d want=1,0,2", out_valid, out_opA, bypass_count); end
    applyStimulus(1'b0, '0, 1'b0, 5'd0, '0, 1'b1);
    step();
  endtask

  task automatic test_same_src();
    applyStimulus(1'b1, rType(5'd9, 5'd9, 5'd1, 6'h24), 1'b1, 5'd9, 32'h0BADF00D, 1'b1);
    step();
    total++; if ({out_opA, out_opB} !== {32'h0BADF00D, 32'h0BADF00D}) begin bad++; $display("[TB] FAIL same_src got=%h,%h want=0badf00d x2", out_opA, out_opB); end
    total++; if (bypass_count !== 6'd3) begin bad++; $display("[TB] FAIL same_src_count got=%0d want=3", bypass_count); end
    applyStimulus(1'b0, '0, 1'b0, 5'd0, '0, 1'b1);
    step();
  endtask

  task automatic test_random_stream();
    logic [5:0] opcs [6] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23};
    logic [31:0] r, ins;
    logic [4:0] wa;
    for (int n = 0; n < 300; n++) begin
      r = $urandom();
      ins = {opcs[$urandom_range(0, 5)], r[25:0]};
      case ($urandom_range(0, 3))
        0: wa = ins[25:21];
        1: wa = mRs;
        2: wa = 5'd0;
        default: wa = 5'($urandom_range(0, 31));
      endcase
      applyStimulus($urandom_range(0, 3) != 0, ins, $urandom_range(0, 1) == 1, wa,
                    $urandom(), $urandom_range(0, 4) > 1);
      #1;
      total++; if (in_ready !== (!mValid || out_ready)) begin bad++; $display("[TB] FAIL rand_in_ready[%0d] got=%b want=%b", n, in_ready, !mValid || out_ready); end
      step();
      total++;
      if ({out_valid, out_opA, out_opB, out_imm, out_rd, out_opcode, out_funct} !==
          {mValid, mOpA, mOpB, mImm, mRd, mOpc, mFunct}) begin
        bad++;
        $display("[TB] FAIL rand_payload[%0d] got=%b %h %h %h %0d %h %h want=%b %h %h %h %0d %h %h", n,
                 out_valid, out_opA, out_opB, out_imm, out_rd, out_opcode, out_funct,
                 mValid, mOpA, mOpB, mImm, mRd, mOpc, mFunct);
      end
      total++; if (bypass_count !== CW'(mCount)) begin bad++; $display("[TB] FAIL rand_count[%0d] got=%0d want=%0d", n, bypass_count, mCount); end
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < CNT_MAX + 6; n++) begin
      applyStimulus(1'b1, iType(6'h08, 5'd1, 5'd2, 16'h0000), 1'b1, 5'd1, $urandom(), 1'b1);
      step();
      total++; if (bypass_count !== CW'(mCount)) begin bad++; $display("[TB] FAIL sat_count[%0d] got=%0d want=%0d", n, bypass_count, mCount); end
    end
    total++; if (bypass_count !== CW'(CNT_MAX)) begin bad++; $display("[TB] FAIL sat_final got=%0d want=%0d", bypass_count, CNT_MAX); end
    applyStimulus(1'b0, '0, 1'b0, 5'd0, '0, 1'b1);
    step();
  endtask

  task automatic test_reset_mid_hold();
    applyStimulus(1'b1, iType(6'h0D, 5'd4, 5'd8, 16'h1234), 1'b0, 5'd0, '0, 1'b0);
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre_valid got=%b want=1", out_valid); end
    applyStimulus(1'b0, '0, 1'b0, 5'd0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_async_valid got=%b want=0", out_valid); end
    total++; if ({out_opA, out_opB, out_imm, out_rd, out_opcode, out_funct, bypass_count} !== '0) begin bad++; $display("[TB] FAIL midrst_payload got=%h %h %h %0d %h %h %0d want=0", out_opA, out_opB, out_imm, out_rd, out_opcode, out_funct, bypass_count); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_in_ready got=%b want=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_stale_valid got=%b want=0", out_valid); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom();
    modelReset();
    test_reset();
    test_basic();
    test_bypass_accept();
    test_hold_update();
    test_imm();
    test_zero_reg();
    test_same_src();
    test_random_stream();
    test_saturation();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
